fsm_sequence_gen: RTL and testbench
===================================

// Module: fsm_sequence_gen
// PURPOSE
//  Serial pattern transmitter; the source side of the 1-1-0-1 detector link.
//  On start, drives PATTERN bit-serially on w, MSB first, one bit per clock.
//  Repeats the pattern reps times with gap idle-zero cycles between repetitions.
//  Signals completion with a one-cycle done pulse.
//  Feeds the detector's w input in the lab top level and in the benches.
// PARAMETERS
//  PATTERN_W  4        pattern length in bits (>=2)
//  PATTERN    4'b1101  pattern transmitted, MSB first
//  REPS_W     8        width of reps input
//  GAP_W      4        width of gap input
// PORTS
//  clock    in   1         single clock, rising edge
//  reset    in   1         asynchronous, active-low reset
//  start    in   1         request; sampled only in IDLE
//  reps     in   REPS_W    repetition count, latched on accepted start
//  gap      in   GAP_W     idle cycles between repetitions, latched on start
//  w        out  1         serial bit out (registered)
//  valid    out  1         high while w carries a pattern bit
//  busy     out  1         high from cycle after accepted start until done
//  done     out  1         one-cycle pulse at end of job
// BEHAVIOUR
//  - reset low (async): state IDLE; w=0, valid=0, busy=0, done=0; counters cleared.
//  - All outputs are registered. No combinational path from inputs to outputs.
//  - FSM states: IDLE, SEND, GAP, DONE. Encoding is one-hot-free 2-bit.
//  - IDLE:
//    - start=1 at edge k with reps>0: latch reps/gap; go to SEND.
//    - From edge k: w=PATTERN[PATTERN_W-1], valid=1, busy=1.
//    - start=1 with reps==0: go to DONE; no bits sent; done=1 after edge k.
//  - SEND:
//    - bit index counts down PATTERN_W-1..0; w=PATTERN[idx], valid=1.
//    - After the bit-0 cycle, with repetitions remaining and gap>0: go to GAP.
//    - After the bit-0 cycle, with repetitions remaining and gap==0: restart at MSB,
//      back-to-back with no bubble.
//    - After the bit-0 cycle, with the last repetition finished: go to DONE.
//  - GAP: w=0, valid=0, busy=1 for exactly gap cycles; then SEND at MSB.
//  - DONE: done=1, busy=0, w=0, valid=0 for one cycle; then IDLE.
//  - start is ignored while busy or in DONE. No queueing.
//  - Latched reps/gap are unaffected by input changes mid-job.
//  - Job length in cycles: reps*PATTERN_W + (reps-1)*gap, plus 1 DONE cycle.
//  - Reset asserted mid-job aborts immediately: outputs 0, no done pulse.
//  - Illegal state code: next state IDLE, all outputs 0.
// CONFIGURATION
//  SEQ_GEN_FRAME_MARK_EN defined:
//    - Adds output frame_end (1 bit, reset 0), high during the cycle w carries
//      PATTERN bit 0 of each repetition.
//    - Aligns with the detector's Mealy z for PATTERN=1101.
//  SEQ_GEN_FRAME_MARK_EN undefined:
//    - Port and logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Package seq_pkg holds:
//    - state encoding constants: IDLE=2'b00, SEND=2'b01, GAP=2'b10, DONE=2'b11
//    - SEQ_DEFAULT_PATTERN = 4'b1101
//    - SEQ_DEFAULT_PATTERN_W = 4
//  - One sub-module, seq_down_counter (parameterised width; load, dec, zero flag).
//  - Instantiated three times: bit index, repetitions, gap.
// TESTING
//  1. Reset low mid-SEND (reps=3): outputs 0 asynchronously.
//     Release, then start: fresh job from MSB.
//  2. reps=1, gap=0, start pulse: w=1,1,0,1 with valid=1 for 4 cycles.
//     Then done=1 for one cycle; busy=1 exactly 4 cycles.
//  3. reps=2, gap=0: w=1,1,0,1,1,1,0,1 back-to-back; done after 8 bit cycles.
//  4. reps=2, gap=3: w=1101,000,1101; valid low on gap cycles.
//     11 busy cycles, then done.
//  5. reps=0 with start: no valid cycle; done=1 on the next cycle.
//     start held high during a reps=2 job: exactly one job runs.
//  6. Loopback to detector, reps=3, gap=0: detector z pulses 3 times.
//     With SEQ_GEN_FRAME_MARK_EN, frame_end is coincident with each z.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg -- shared definitions for the serial pattern transmitter.
//   state_t               : 2-bit FSM encoding (IDLE/SEND/GAP/DONE)
//   SEQ_DEFAULT_PATTERN   : pattern sent by default, MSB first
//   SEQ_DEFAULT_PATTERN_W : its length in bits
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SEND = 2'b01,
        S_GAP  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam int          SEQ_DEFAULT_PATTERN_W = 4;
    localparam logic [3:0]  SEQ_DEFAULT_PATTERN   = 4'b1101;

endpackage

// File: rtl/seq_down_counter.sv
// seq_down_counter -- loadable down counter with a zero flag.
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset (count cleared)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; holds at zero
//   count    : current count
//   zero     : count == 0
module seq_down_counter #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/fsm_sequence_gen.sv
// fsm_sequence_gen -- serial pattern transmitter (source of the 1101 link).
// On an accepted start, sends PATTERN MSB first on w, reps times, with gap
// idle-zero cycles between repetitions, then pulses done for one cycle.
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset
//   start     : job request, only looked at in IDLE
//   reps      : repetition count, latched on accepted start
//   gap       : idle cycles between repetitions, latched on accepted start
//   w         : serial bit (registered)
//   valid     : w carries a pattern bit
//   busy      : job in progress (SEND/GAP)
//   done      : one-cycle end-of-job pulse
//   frame_end : only with SEQ_GEN_FRAME_MARK_EN; high while w carries bit 0
// Build option: define SEQ_GEN_FRAME_MARK_EN to add the frame_end output.
module fsm_sequence_gen
    import seq_pkg::*;
#(
    parameter int                   PATTERN_W = SEQ_DEFAULT_PATTERN_W,
    parameter logic [PATTERN_W-1:0] PATTERN   = SEQ_DEFAULT_PATTERN,
    parameter int                   REPS_W    = 8,
    parameter int                   GAP_W     = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [REPS_W-1:0] reps,
    input  logic [GAP_W-1:0]  gap,
    output logic              w,
    output logic              valid,
    output logic              busy,
`ifdef SEQ_GEN_FRAME_MARK_EN
    output logic              frame_end,
`endif
    output logic              done
);

    localparam int IDX_W = $clog2(PATTERN_W);

    state_t state_q, state_d;
    logic w_q, w_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic fe_q, fe_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    // Index of the bit currently on w; zero means the bit-0 cycle.
    logic             idx_load, idx_dec, idx_zero;
    logic [IDX_W-1:0] idx_cnt;
    // Repetitions still to start after the current one.
    logic              rep_load, rep_dec, rep_zero;
    logic [REPS_W-1:0] rep_cnt;
    // Gap cycles remaining after the current one.
    logic             gap_load, gap_dec, gap_zero;
    logic [GAP_W-1:0] gap_cnt;

    seq_down_counter #(.W(IDX_W)) u_idx_cnt (
        .clock(clock), .reset(reset), .load(idx_load),
        .load_val(IDX_W'(PATTERN_W - 1)), .dec(idx_dec),
        .count(idx_cnt), .zero(idx_zero)
    );

    seq_down_counter #(.W(REPS_W)) u_rep_cnt (
        .clock(clock), .reset(reset), .load(rep_load),
        .load_val(reps - REPS_W'(1)), .dec(rep_dec),
        .count(rep_cnt), .zero(rep_zero)
    );

    seq_down_counter #(.W(GAP_W)) u_gap_cnt (
        .clock(clock), .reset(reset), .load(gap_load),
        .load_val(gap_q - GAP_W'(1)), .dec(gap_dec),
        .count(gap_cnt), .zero(gap_zero)
    );

    // Only the zero flags of the repetition and gap counters are needed.
    logic unused_cnt;
    assign unused_cnt = ^{rep_cnt, gap_cnt};

    // Outputs are computed one cycle ahead and registered, so every output
    // reflects the state entered at the same edge.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        w_d      = 1'b0;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        fe_d     = 1'b0;
        idx_load = 1'b0;
        idx_dec  = 1'b0;
        rep_load = 1'b0;
        rep_dec  = 1'b0;
        gap_load = 1'b0;
        gap_dec  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (reps != '0) begin
                        state_d  = S_SEND;
                        gap_d    = gap;
                        rep_load = 1'b1;
                        idx_load = 1'b1;
                        w_d      = PATTERN[PATTERN_W-1];
                        valid_d  = 1'b1;
                        busy_d   = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_SEND: begin
                busy_d = 1'b1;
                if (!idx_zero) begin
                    idx_dec = 1'b1;
                    w_d     = PATTERN[idx_cnt - IDX_W'(1)];
                    valid_d = 1'b1;
                    fe_d    = (idx_cnt == IDX_W'(1));
                end else if (rep_zero) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    rep_dec = 1'b1;
                    if (gap_q != '0) begin
                        state_d  = S_GAP;
                        gap_load = 1'b1;
                    end else begin
                        // Back-to-back repetition: MSB follows bit 0 directly.
                        idx_load = 1'b1;
                        w_d      = PATTERN[PATTERN_W-1];
                        valid_d  = 1'b1;
                    end
                end
            end
            S_GAP: begin
                busy_d = 1'b1;
                if (gap_zero) begin
                    state_d  = S_SEND;
                    idx_load = 1'b1;
                    w_d      = PATTERN[PATTERN_W-1];
                    valid_d  = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            w_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            w_q     <= w_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fe_q    <= fe_d;
        end
    end

    assign w     = w_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

`ifdef SEQ_GEN_FRAME_MARK_EN
    assign frame_end = fe_q;
`else
    logic unused_fe;
    assign unused_fe = fe_q;
`endif

endmodule

// File: tb/tb_fsm_sequence_gen.sv
// tb_fsm_sequence_gen -- scoreboard bench for fsm_sequence_gen.
// Expected per-cycle outputs are pushed when a job is launched and popped
// one per clock as the DUT produces them. A tiny 1101 Mealy detector on w
// provides the loopback count.
module tb_fsm_sequence_gen;

    localparam logic [3:0] PAT = 4'b1101;

    typedef struct packed {
        logic w;
        logic valid;
        logic busy;
        logic done;
        logic fe;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] reps  = '0;
    logic [3:0] gap   = '0;
    logic       w, valid, busy, done;
`ifdef SEQ_GEN_FRAME_MARK_EN
    logic       frame_end;
`endif

    int n_cmp = 0;
    int n_err = 0;
    exp_t sb_q[$];

    fsm_sequence_gen dut (
        .clock(clock), .reset(reset), .start(start), .reps(reps), .gap(gap),
        .w(w), .valid(valid), .busy(busy),
`ifdef SEQ_GEN_FRAME_MARK_EN
        .frame_end(frame_end),
`endif
        .done(done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Independent reference of a whole job, one entry per cycle after the start edge.
    task automatic push_job(input int r, input int g);
        exp_t e;
        for (int k = 0; k < r; k++) begin
            for (int b = 3; b >= 0; b--) begin
                e = '{w: PAT[b], valid: 1'b1, busy: 1'b1, done: 1'b0, fe: (b == 0)};
                sb_q.push_back(e);
            end
            if (k < r - 1) begin
                for (int j = 0; j < g; j++) begin
                    e = '{w: 1'b0, valid: 1'b0, busy: 1'b1, done: 1'b0, fe: 1'b0};
                    sb_q.push_back(e);
                end
            end
        end
        e = '{w: 1'b0, valid: 1'b0, busy: 1'b0, done: 1'b1, fe: 1'b0};
        sb_q.push_back(e);
        e = '{w: 1'b0, valid: 1'b0, busy: 1'b0, done: 1'b0, fe: 1'b0};
        sb_q.push_back(e);
    endtask

    // Launch a job and compare until the scoreboard drains (or n_abort samples).
    // Called with time just after a rising edge.
    task automatic run_job(input int r, input int g, input bit hold, input int n_abort,
                           output int zc);
        exp_t e;
        logic [2:0] hist;
        logic z;
        int n;
        hist = '0;
        zc   = 0;
        n    = 0;
        push_job(r, g);
        reps  = 8'(r);
        gap   = 4'(g);
        start = 1'b1;
        while (sb_q.size() > 0) begin
            @(posedge clock);
            #1;
            if (!hold) start = 1'b0;
            // Scramble inputs: latched values must not follow them.
            reps = 8'($urandom_range(0, 255));
            gap  = 4'($urandom_range(0, 15));
            e = sb_q.pop_front();
            chk("outs_wvbd", 8'({w, valid, busy, done}), 8'({e.w, e.valid, e.busy, e.done}));
            z = (hist == 3'b110) && w;
            if (z) zc++;
            hist = {hist[1:0], w};
`ifdef SEQ_GEN_FRAME_MARK_EN
            chk("frame_end", 8'(frame_end), 8'(e.fe));
            chk("fe_vs_z", 8'(frame_end), 8'(z));
`endif
            if (e.done) start = 1'b0;
            n++;
            if (n_abort > 0 && n >= n_abort) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        int zc;
        // Reset state
        #3;
        chk("rst_state", 8'({w, valid, busy, done}), 8'h0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("idle_after_rst", 8'({w, valid, busy, done}), 8'h0);

        // 1. Reset mid-SEND aborts, then a fresh job starts at the MSB
        run_job(3, 0, 1'b0, 6, zc);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_outs", 8'({w, valid, busy, done}), 8'h0);
        sb_q.delete();
        @(posedge clock);
        #1;
        chk("rst_held_outs", 8'({w, valid, busy, done}), 8'h0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("no_done_after_abort", 8'({w, valid, busy, done}), 8'h0);
        run_job(1, 0, 1'b0, 0, zc);

        // 2-4. Single, back-to-back and gapped repetitions
        run_job(1, 0, 1'b0, 0, zc);
        run_job(2, 0, 1'b0, 0, zc);
        run_job(2, 3, 1'b0, 0, zc);
        run_job(3, 1, 1'b0, 0, zc);

        // 5. reps=0 gives only a done pulse; held start runs exactly one job
        run_job(0, 5, 1'b0, 0, zc);
        run_job(2, 2, 1'b1, 0, zc);

        // 6. Loopback: three back-to-back frames give three detections
        run_job(3, 0, 1'b0, 0, zc);
        chk("loop_z_count", 8'(zc), 8'd3);
        run_job(2, 15, 1'b0, 0, zc);
        chk("loop_z_gap", 8'(zc), 8'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
